unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle_pkg.sv | 50 +++++
 rtl/unidade_controle_decodificador.sv | 63 ++++++
 rtl/unidade_controle.sv | 133 +++++++++++++
 tb/tb_unidade_controle.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared constants, state encoding and control-word layout for the RV64 subset controller.
package unidade_controle_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  localparam logic [2:0] F3_DWORD = 3'b011;
  localparam logic [2:0] F3_ADD   = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [1:0] SEL_A_DEF = 2'd1;
  localparam logic [1:0] SEL_B_DEF = 2'd0;
  localparam logic [1:0] SEL_C_DEF = 2'd2;

  typedef enum logic [2:0] {
    OCIOSO,
    DECODIFICA,
    EXECUTA,
    MEMORIA,
    ESCRITA
  } estado_t;

  typedef enum logic [1:0] {
    CL_ALU,
    CL_LD,
    CL_SD,
    CL_ILEGAL
  } classe_t;

  typedef struct packed {
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [63:0] imm;
    logic [1:0]  ent1;
    logic [1:0]  ent2;
    logic        soma;
    logic        sub;
    classe_t     classe;
  } ctrl_t;

  function automatic logic [63:0] sext12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction

endpackage

// File: rtl/unidade_controle_decodificador.sv
// Combinational decode of one instruction word into the controller's control word.
module unidade_controle_decodificador
  import unidade_controle_pkg::*;
#(
  parameter logic [1:0] SEL_A = SEL_A_DEF,
  parameter logic [1:0] SEL_B = SEL_B_DEF,
  parameter logic [1:0] SEL_C = SEL_C_DEF
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        ilegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl        = '0;
    ctrl.classe = CL_ILEGAL;
    ilegal      = 1'b1;

    if (opcode == OP_LOAD && funct3 == F3_DWORD) begin
      ctrl.classe = CL_LD;
      ctrl.imm    = sext12(instr[31:20]);
      ilegal      = 1'b0;
    end else if (opcode == OP_STORE && funct3 == F3_DWORD) begin
      ctrl.classe = CL_SD;
      ctrl.imm    = sext12({instr[31:25], instr[11:7]});
      ilegal      = 1'b0;
    end else if (opcode == OP_IMM && funct3 == F3_ADD) begin
      ctrl.classe = CL_ALU;
      ctrl.imm    = sext12(instr[31:20]);
      ilegal      = 1'b0;
    end else if (opcode == OP_OP && funct3 == F3_ADD &&
                 (funct7 == F7_ADD || funct7 == F7_SUB)) begin
      ctrl.classe = CL_ALU;
      ilegal      = 1'b0;
    end

    // Illegal words leave the whole control word at zero.
    if (!ilegal) begin
      ctrl.ra   = instr[19:15];
      ctrl.rb   = instr[24:20];
      ctrl.rw   = instr[11:7];
      ctrl.soma = 1'b1;
      if (opcode == OP_OP) begin
        ctrl.ent1 = SEL_A;
        ctrl.ent2 = SEL_B;
        ctrl.sub  = funct7[5];
      end else begin
        ctrl.ent1 = SEL_C;
        ctrl.ent2 = SEL_A;
        ctrl.sub  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle controller for ld/sd/add/sub/addi: accepts one instruction at a time and
// sequences register-file, ALU and data-memory strobes.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter logic [1:0] SEL_A = SEL_A_DEF,
  parameter logic [1:0] SEL_B = SEL_B_DEF,
  parameter logic [1:0] SEL_C = SEL_C_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  Ra,
  output logic [4:0]  Rb,
  output logic [4:0]  Rw,
  output logic        WeR,
  output logic        WeM,
  output logic [63:0] constante,
  output logic        soma_ou_subtrai,
  output logic        subtraindo,
  output logic [1:0]  escolhe_entrada1,
  output logic [1:0]  escolhe_entrada2,
  output logic        sel_dinR,
  output logic        done,
  output logic        erro
);

  // state      | meaning
  // OCIOSO     | waiting for instr_valid; instr_ready high
  // DECODIFICA | control word latched; erro pulses here for illegal words
  // EXECUTA    | ALU cycle; sd writes memory and retires here
  // MEMORIA    | ld only: one cycle for the synchronous memory read
  // ESCRITA    | register write-back and done pulse

  estado_t estado;
  ctrl_t   dec;
  ctrl_t   ctrl_q;
  logic    dec_ilegal;

  unidade_controle_decodificador #(
    .SEL_A(SEL_A),
    .SEL_B(SEL_B),
    .SEL_C(SEL_C)
  ) u_dec (
    .instr (instr),
    .ctrl  (dec),
    .ilegal(dec_ilegal)
  );

  assign Ra               = ctrl_q.ra;
  assign Rb               = ctrl_q.rb;
  assign Rw               = ctrl_q.rw;
  assign constante        = ctrl_q.imm;
  assign soma_ou_subtrai  = ctrl_q.soma;
  assign subtraindo       = ctrl_q.sub;
  assign escolhe_entrada1 = ctrl_q.ent1;
  assign escolhe_entrada2 = ctrl_q.ent2;

  // The decoded word is captured at the handshake so erro can pulse in DECODIFICA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= OCIOSO;
      ctrl_q      <= '0;
      instr_ready <= 1'b0;
      WeR         <= 1'b0;
      WeM         <= 1'b0;
      sel_dinR    <= 1'b0;
      done        <= 1'b0;
      erro        <= 1'b0;
    end else begin
      WeR      <= 1'b0;
      WeM      <= 1'b0;
      sel_dinR <= 1'b0;
      done     <= 1'b0;
      erro     <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (instr_ready && instr_valid) begin
            ctrl_q      <= dec;
            erro        <= dec_ilegal;
            instr_ready <= 1'b0;
            estado      <= DECODIFICA;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        DECODIFICA: begin
          if (ctrl_q.classe == CL_ILEGAL) begin
            estado      <= OCIOSO;
            instr_ready <= 1'b1;
          end else begin
            estado <= EXECUTA;
            if (ctrl_q.classe == CL_SD) begin
              WeM  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        EXECUTA: begin
          case (ctrl_q.classe)
            CL_SD: begin
              estado      <= OCIOSO;
              instr_ready <= 1'b1;
            end
            CL_LD: estado <= MEMORIA;
            default: begin
              estado <= ESCRITA;
              WeR    <= (ctrl_q.rw != 5'd0);
              done   <= 1'b1;
            end
          endcase
        end
        MEMORIA: begin
          estado   <= ESCRITA;
          WeR      <= (ctrl_q.rw != 5'd0);
          sel_dinR <= 1'b1;
          done     <= 1'b1;
        end
        ESCRITA: begin
          estado      <= OCIOSO;
          instr_ready <= 1'b1;
        end
        default: begin
          estado      <= OCIOSO;
          instr_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench: the driver queues the expected retire event per instruction,
// the monitor pops and compares whenever done/erro/WeR/WeM appears.
module tb_unidade_controle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [4:0]  Ra, Rb, Rw;
  logic        WeR, WeM;
  logic [63:0] constante;
  logic        soma_ou_subtrai, subtraindo;
  logic [1:0]  escolhe_entrada1, escolhe_entrada2;
  logic        sel_dinR, done, erro;

  unidade_controle dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Ra(Ra), .Rb(Rb), .Rw(Rw), .WeR(WeR), .WeM(WeM),
    .constante(constante), .soma_ou_subtrai(soma_ou_subtrai), .subtraindo(subtraindo),
    .escolhe_entrada1(escolhe_entrada1), .escolhe_entrada2(escolhe_entrada2),
    .sel_dinR(sel_dinR), .done(done), .erro(erro)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic        er, dn, wr, wm, sd;
    logic [4:0]  rw, ra, rb;
    logic [63:0] imm;
    logic [1:0]  e1, e2;
    logic        sub;
    bit          chk;
    int          tcyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   want_ready = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int lat, input logic er, dn, wr, wm, sd,
                              input logic [4:0] rw, ra, rb, input logic [63:0] imm,
                              input logic [1:0] e1, e2, input logic sub, input bit chk);
    exp_t e;
    e.lat = lat; e.er = er; e.dn = dn; e.wr = wr; e.wm = wm; e.sd = sd;
    e.rw = rw; e.ra = ra; e.rb = rb; e.imm = imm; e.e1 = e1; e.e2 = e2;
    e.sub = sub; e.chk = chk; e.tcyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (want_ready) begin
        check("ready_after_retire", instr_ready, 1);
        want_ready = 0;
      end
      if (done || erro || WeR || WeM) begin
        check("wer_wem_exclusive", WeR && WeM, 0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event actual=done%0b erro%0b WeR%0b WeM%0b required=none",
                   done, erro, WeR, WeM);
        end else begin
          e = q.pop_front();
          check("event_cycle", cyc, e.tcyc);
          check("erro", erro, e.er);
          check("done", done, e.dn);
          check("WeR", WeR, e.wr);
          check("WeM", WeM, e.wm);
          check("sel_dinR", sel_dinR, e.sd);
          check("Rw", Rw, e.rw);
          if (e.chk) begin
            check("Ra", Ra, e.ra);
            check("Rb", Rb, e.rb);
            check("constante", constante, e.imm);
            check("entrada1", escolhe_entrada1, e.e1);
            check("entrada2", escolhe_entrada2, e.e2);
            check("subtraindo", subtraindo, e.sub);
            check("soma_ou_subtrai", soma_ou_subtrai, 1);
          end
          want_ready = 1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] w, input exp_t e);
    int n;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      check("handshake_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    e.tcyc = cyc + e.lat;
    q.push_back(e);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = '0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("retire_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, instr_ready, 0);
    check({tag, "_WeR"}, WeR, 0);
    check({tag, "_WeM"}, WeM, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_erro"}, erro, 0);
    check({tag, "_sel_dinR"}, sel_dinR, 0);
    check({tag, "_Rw"}, Rw, 0);
    check({tag, "_Ra"}, Ra, 0);
    check({tag, "_constante"}, constante, 0);
    check({tag, "_entrada1"}, escolhe_entrada1, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", instr_ready, 1);

    send(32'h0010_3083, mk(4, 0, 1, 1, 0, 1, 5'd1, 5'd0, 5'd1, 64'd1, 2'd2, 2'd1, 0, 1));
    send(32'h0010_32A3, mk(2, 0, 1, 0, 1, 0, 5'd5, 5'd0, 5'd1, 64'd5, 2'd2, 2'd1, 0, 1));
    send(32'h4020_8233, mk(3, 0, 1, 1, 0, 0, 5'd4, 5'd1, 5'd2, 64'd0, 2'd1, 2'd0, 1, 1));
    send(32'h0020_81B3, mk(3, 0, 1, 1, 0, 0, 5'd3, 5'd1, 5'd2, 64'd0, 2'd1, 2'd0, 0, 1));
    send(32'hFE92_8313, mk(3, 0, 1, 1, 0, 0, 5'd6, 5'd5, 5'd9, 64'hFFFF_FFFF_FFFF_FFE9,
                           2'd2, 2'd1, 0, 1));
    send(32'h1E70_8293, mk(3, 0, 1, 1, 0, 0, 5'd5, 5'd1, 5'd7, 64'd487, 2'd2, 2'd1, 0, 1));
    send(32'h0000_007F, mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 64'd0, 2'd0, 2'd0, 0, 0));
    send(32'h6020_8233, mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 64'd0, 2'd0, 2'd0, 0, 0));
    send(32'h0010_2083, mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 64'd0, 2'd0, 2'd0, 0, 0));
    send(32'h0010_0013, mk(3, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd1, 64'd1, 2'd2, 2'd1, 0, 1));

    // ld aborted by reset while in MEMORIA
    @(negedge clk);
    instr = 32'h0010_3083;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_handshake", instr_ready, 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = '0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    repeat (2) @(negedge clk);
    check("abort_WeR_held", WeR, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", instr_ready, 1);

    send(32'h0010_3083, mk(4, 0, 1, 1, 0, 1, 5'd1, 5'd0, 5'd1, 64'd1, 2'd2, 2'd1, 0, 1));
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
